// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite colour mapper and its per-sprite
// coverage lanes.
package sprite_pkg;

    localparam int MAX_SPR = 8;
    localparam int IDX_W   = $clog2(MAX_SPR);
    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        BG_GRADIENT = 1'b0,
        BG_SOLID    = 1'b1
    } bg_mode_e;

    // Column-banded blue ramp; col is DrawX[9:3].
    function automatic logic [7:0] gradient_blue(input logic [6:0] col);
        return 8'h7F - {1'b0, col};
    endfunction

endpackage

// File: rtl/sprite_cov_lane.sv
// One sprite's coverage test: signed offsets and squares in stage 1, the
// square/circle decision in stage 2. Sprite attributes ride along with the pixel.
module sprite_cov_lane
    import sprite_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic [CW-1:0] draw_x,
    input  logic [CW-1:0] draw_y,
    input  logic [CW-1:0] spr_x,
    input  logic [CW-1:0] spr_y,
    input  logic [CW-1:0] spr_size,
    input  logic          spr_en,
    input  logic          spr_mode,
    input  rgb_t          spr_color,
    output logic          cov,
    output rgb_t          color
);

    localparam int SQ_W  = 2*CW + 2;
    localparam int SUM_W = 2*CW + 3;

    function automatic logic [CW-1:0] magnitude(input logic signed [CW:0] d);
        return CW'(d[CW] ? -d : d);
    endfunction

    function automatic logic [SQ_W-1:0] square(input logic [CW-1:0] a);
        return SQ_W'(a) * SQ_W'(a);
    endfunction

    logic signed [CW:0] dx, dy;
    logic [CW-1:0]      adx, ady;

    // Zero-extend before subtracting so edge sprites clip instead of wrapping.
    assign dx  = $signed({1'b0, draw_x}) - $signed({1'b0, spr_x});
    assign dy  = $signed({1'b0, draw_y}) - $signed({1'b0, spr_y});
    assign adx = magnitude(dx);
    assign ady = magnitude(dy);

    // Stage 1
    logic            in_box_p1, en_p1, mode_p1;
    logic [SQ_W-1:0] dx2_p1, dy2_p1, size2_p1;
    rgb_t            color_p1;

    always_ff @(posedge clk) begin
        in_box_p1 <= (adx <= spr_size) && (ady <= spr_size);
        dx2_p1    <= square(adx);
        dy2_p1    <= square(ady);
        size2_p1  <= square(spr_size);
        en_p1     <= spr_en;
        mode_p1   <= spr_mode;
        color_p1  <= spr_color;
    end

    // Stage 2
    logic [SUM_W-1:0] dist2;

    assign dist2 = SUM_W'(dx2_p1) + SUM_W'(dy2_p1);

    always_ff @(posedge clk) begin
        cov   <= en_p1 && in_box_p1 && (!mode_p1 || dist2 <= SUM_W'(size2_p1));
        color <= color_p1;
    end

endmodule

// File: rtl/sprite_color_mapper.sv
// Multi-sprite pixel colour resolver: per-frame shadowed sprite geometry,
// two-stage coverage pipeline and fixed lowest-index-wins priority.
module sprite_color_mapper
    import sprite_pkg::*;
#(
    parameter int          NUM_SPR  = 4,
    parameter int          CW       = 10,
    parameter int          BG_MODE  = 0,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [CW-1:0]           DrawX,
    input  logic [CW-1:0]           DrawY,
    input  logic [NUM_SPR*CW-1:0]   SprX,
    input  logic [NUM_SPR*CW-1:0]   SprY,
    input  logic [NUM_SPR*CW-1:0]   SprSize,
    input  logic [NUM_SPR-1:0]      SprEn,
    input  logic [NUM_SPR-1:0]      SprMode,
    input  logic [NUM_SPR*24-1:0]   SprColor,
    output logic [7:0]              Red,
    output logic [7:0]              Green,
    output logic [7:0]              Blue,
    output logic                    out_valid,
    output logic                    hit,
    output logic [IDX_W-1:0]        hit_idx
);

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic [NUM_SPR*CW-1:0] sh_x, sh_y, sh_size;
    logic [NUM_SPR-1:0]    sh_en, sh_mode;
    logic [NUM_SPR*24-1:0] sh_color;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_size  <= '0;
            sh_en    <= '0;
            sh_mode  <= '0;
            sh_color <= '0;
        end else if (frame_start) begin
            sh_x     <= SprX;
            sh_y     <= SprY;
            sh_size  <= SprSize;
            sh_en    <= SprEn;
            sh_mode  <= SprMode;
            sh_color <= SprColor;
        end
    end

    // Stage 1 / stage 2 delay line for valid and the gradient column
    logic       vld_p1, vld_p2;
    logic [6:0] grad_p1, grad_p2;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge Clk) begin
        grad_p1 <= DrawX[9:3];
        grad_p2 <= grad_p1;
    end

    logic [NUM_SPR-1:0] cov_p2;
    rgb_t               color_p2 [NUM_SPR];

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_lane
        sprite_cov_lane #(.CW(CW)) u_lane (
            .clk       (Clk),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .spr_x     (sh_x[i*CW +: CW]),
            .spr_y     (sh_y[i*CW +: CW]),
            .spr_size  (sh_size[i*CW +: CW]),
            .spr_en    (sh_en[i]),
            .spr_mode  (sh_mode[i]),
            .spr_color (sh_color[i*24 +: 24]),
            .cov       (cov_p2[i]),
            .color     (color_p2[i])
        );
    end

    rgb_t             bg_color, sel_color, hold_color;
    logic             sel_hit, hold_hit;
    logic [IDX_W-1:0] sel_idx, hold_idx;

    assign bg_color = (BG_MODE == int'(BG_SOLID)) ? rgb_t'(BG_COLOR)
                                                  : rgb_t'({16'h0000, gradient_blue(grad_p2)});

    // Scan high to low so the lowest covering index is the last assignment.
    always_comb begin
        sel_color = bg_color;
        sel_hit   = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (cov_p2[i]) begin
                sel_color = color_p2[i];
                sel_hit   = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_color <= '0;
            hold_hit   <= 1'b0;
            hold_idx   <= '0;
        end else if (vld_p2) begin
            hold_color <= sel_color;
            hold_hit   <= sel_hit;
            hold_idx   <= sel_idx;
        end
    end

    assign out_valid          = vld_p2;
    assign {Red, Green, Blue} = vld_p2 ? sel_color : hold_color;
    assign hit                = vld_p2 ? sel_hit   : hold_hit;
    assign hit_idx            = vld_p2 ? sel_idx   : hold_idx;

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Directed and randomized checks of sprite_color_mapper against a plain
// arithmetic model of sprite coverage, priority and background.
module tb_sprite_color_mapper;

    localparam int NS = 4;

    typedef logic [28:0] pix_t;   // {out_valid, hit, hit_idx[2:0], R, G, B}

    logic          Clk = 1'b0;
    logic          Reset_n, frame_start, pix_valid;
    logic [9:0]    DrawX, DrawY;
    logic [39:0]   SprX, SprY, SprSize;
    logic [3:0]    SprEn, SprMode;
    logic [95:0]   SprColor;
    logic [7:0]    Red, Green, Blue;
    logic          out_valid, hit;
    logic [2:0]    hit_idx;

    always #5 Clk = ~Clk;

    sprite_color_mapper #(.NUM_SPR(NS), .CW(10), .BG_MODE(0), .BG_COLOR(24'h000000)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY), .SprSize(SprSize),
        .SprEn(SprEn), .SprMode(SprMode), .SprColor(SprColor),
        .Red(Red), .Green(Green), .Blue(Blue),
        .out_valid(out_valid), .hit(hit), .hit_idx(hit_idx)
    );

    // Live sprite inputs and the model's copy of what the block latched
    logic [9:0]  lx [NS], ly [NS], ls [NS];
    logic        le [NS], lm [NS];
    logic [23:0] lc [NS];
    logic [9:0]  mx [NS], my [NS], ms [NS];
    logic        me [NS], mm [NS];
    logic [23:0] mc [NS];

    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t last = '0;

    always_comb begin
        SprX = '0; SprY = '0; SprSize = '0; SprEn = '0; SprMode = '0; SprColor = '0;
        for (int i = 0; i < NS; i++) begin
            SprX[i*10 +: 10]    = lx[i];
            SprY[i*10 +: 10]    = ly[i];
            SprSize[i*10 +: 10] = ls[i];
            SprEn[i]            = le[i];
            SprMode[i]          = lm[i];
            SprColor[i*24 +: 24] = lc[i];
        end
    end

    function automatic pix_t obs();
        return {out_valid, hit, hit_idx, Red, Green, Blue};
    endfunction

    function automatic pix_t mk(bit h, int idx, logic [23:0] c);
        return {1'b1, h, 3'(idx), c};
    endfunction

    function automatic pix_t ref_pix(int x, int y);
        int dx, dy, s, ax, ay;
        for (int i = 0; i < NS; i++) begin
            dx = x - int'(mx[i]);
            dy = y - int'(my[i]);
            s  = int'(ms[i]);
            ax = (dx < 0) ? -dx : dx;
            ay = (dy < 0) ? -dy : dy;
            if (me[i] && ax <= s && ay <= s && (!mm[i] || dx*dx + dy*dy <= s*s))
                return mk(1'b1, i, mc[i]);
        end
        return mk(1'b0, 0, {16'h0000, 8'(127 - x/8)});
    endfunction

    task automatic chk(string tag, pix_t o, pix_t e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic set_spr(int i, int x, int y, int s, bit en, bit mode, logic [23:0] c);
        lx[i] = 10'(x); ly[i] = 10'(y); ls[i] = 10'(s);
        le[i] = en; lm[i] = mode; lc[i] = c;
    endtask

    task automatic rand_spr(int i);
        int r, x, y;
        r = int'($urandom_range(0, 3));
        x = (r == 0) ? int'($urandom_range(0, 20)) : (r == 1) ? int'($urandom_range(1003, 1023))
                                                              : int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
        set_spr(i, x, y, int'($urandom_range(0, 40)), $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), 24'($urandom));
    endtask

    task automatic latch_model();
        for (int i = 0; i < NS; i++) begin
            mx[i] = lx[i]; my[i] = ly[i]; ms[i] = ls[i];
            me[i] = le[i]; mm[i] = lm[i]; mc[i] = lc[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) begin
            mx[i] = '0; my[i] = '0; ms[i] = '0; me[i] = 1'b0; mm[i] = 1'b0; mc[i] = '0;
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        latch_model();
    endtask

    // One isolated pixel: idle before, full result two edges later, hold after.
    task automatic single(int x, int y, bit fs, pix_t e, string tag);
        DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1; frame_start = fs;
        @(posedge Clk); #1;
        pix_valid = 1'b0; frame_start = 1'b0;
        if (fs) latch_model();
        chk({tag, "_lat1"}, {28'b0, out_valid}, '0);
        @(posedge Clk); #1;
        chk(tag, obs(), e);
        last = e;
        @(posedge Clk); #1;
        chk({tag, "_hold"}, {out_valid, 4'b0, Red, Green, Blue}, {1'b0, 4'b0, e[23:0]});
    endtask

    task automatic pick_xy(output int x, output int y);
        int j, s;
        j = int'($urandom_range(0, NS - 1));
        s = int'(ls[j]);
        x = int'(lx[j]) + int'($urandom_range(0, 2*s + 8)) - (s + 4);
        y = int'(ly[j]) + int'($urandom_range(0, 2*s + 8)) - (s + 4);
        x = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
        y = (y < 0) ? 0 : (y > 1023) ? 1023 : y;
    endtask

    // Back-to-back pixels with gaps, random frame strobes and live changes.
    task automatic stream(int len, bit drain);
        pix_t q[$];
        pix_t e, o;
        int   x, y, steps;
        bit   fs;
        steps = drain ? len + 2 : len;
        for (int k = 0; k < steps; k++) begin
            if (k < len && $urandom_range(0, 3) != 0) begin
                pick_xy(x, y);
                e = ref_pix(x, y);
                DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
            end else begin
                e = '0;
                pix_valid = 1'b0;
            end
            q.push_back(e);
            fs = (k < len) && ($urandom_range(0, 11) == 0);
            frame_start = fs;
            if ($urandom_range(0, 7) == 0) rand_spr(int'($urandom_range(0, NS - 1)));
            @(posedge Clk); #1;
            frame_start = 1'b0;
            if (fs) latch_model();
            if (q.size() == 2) begin
                e = q.pop_front();
                o = obs();
                if (e[28]) begin
                    chk("stream", o, e);
                    last = e;
                end else begin
                    chk("stream_idle", {o[28], 4'b0, o[23:0]}, {1'b0, 4'b0, last[23:0]});
                end
            end
        end
        if (drain) pix_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
        for (int i = 0; i < NS; i++) set_spr(i, 0, 0, 0, 1'b0, 1'b0, 24'h0);
        clear_model();
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset", obs(), '0);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_release_idle", obs(), '0);

        // Square sprite, visible only after frame_start
        set_spr(0, 100, 100, 10, 1'b1, 1'b0, 24'hFF5500);
        single(110, 90, 0, mk(0, 0, 24'h000072), "no_frame_yet");
        frame();
        single(110, 90, 0, mk(1, 0, 24'hFF5500), "square_corner");
        single(111, 90, 0, mk(0, 0, 24'h000072), "square_outside");

        // Circle sprite
        set_spr(1, 200, 200, 10, 1'b1, 1'b1, 24'h00AA33);
        frame();
        single(207, 207, 0, mk(1, 1, 24'h00AA33), "circle_in");
        single(208, 207, 0, mk(0, 0, 24'h000065), "circle_out");

        // Overlap priority, then disabling the winner
        set_spr(0, 50, 50, 5, 1'b1, 1'b0, 24'h112233);
        set_spr(2, 50, 50, 3, 1'b1, 1'b1, 24'h445566);
        frame();
        single(50, 50, 0, mk(1, 0, 24'h112233), "overlap_idx0");
        le[0] = 1'b0;
        frame();
        single(50, 50, 0, mk(1, 2, 24'h445566), "overlap_idx2");

        // Edge clipping
        set_spr(3, 3, 3, 8, 1'b1, 1'b0, 24'hC0FFEE);
        frame();
        single(639, 3, 0, mk(0, 0, 24'h000030), "edge_no_ghost");
        single(0, 0, 0, mk(1, 3, 24'hC0FFEE), "edge_origin");
        single(11, 3, 0, ref_pix(11, 3), "edge_dx8");
        single(12, 3, 0, ref_pix(12, 3), "edge_dx9");
        single(1023, 1023, 0, ref_pix(1023, 1023), "edge_far_corner");

        // Size zero in both modes
        set_spr(2, 300, 300, 0, 1'b1, 1'b0, 24'h0A0B0C);
        set_spr(1, 400, 400, 0, 1'b1, 1'b1, 24'hD0E0F0);
        frame();
        single(300, 300, 0, mk(1, 2, 24'h0A0B0C), "size0_sq_hit");
        single(301, 300, 0, ref_pix(301, 300), "size0_sq_miss");
        single(400, 400, 0, mk(1, 1, 24'hD0E0F0), "size0_circ_hit");
        single(400, 401, 0, ref_pix(400, 401), "size0_circ_miss");

        // Tearing: live move is invisible until frame_start takes effect
        lx[3] = 10'd500;
        single(0, 0, 0, mk(1, 3, 24'hC0FFEE), "tear_no_frame");
        single(0, 0, 1, mk(1, 3, 24'hC0FFEE), "tear_same_cycle");
        single(0, 0, 0, mk(0, 0, 24'h00007F), "tear_after");
        single(500, 3, 0, mk(1, 3, 24'hC0FFEE), "tear_new_pos");

        // Randomized streaming
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NS; i++) rand_spr(i);
            frame();
            stream(40, 1'b1);
        end

        // Reset in the middle of a streaming line
        for (int i = 0; i < NS; i++) rand_spr(i);
        frame();
        stream(12, 1'b0);
        DrawX = 10'd5; DrawY = 10'd5; pix_valid = 1'b1;
        @(posedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        chk("reset_midline_async", obs(), '0);
        pix_valid = 1'b0;
        @(posedge Clk); #1;
        chk("reset_midline_held", obs(), '0);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_midline_release", obs(), '0);
        clear_model();
        last = '0;

        set_spr(0, 600, 200, 20, 1'b1, 1'b0, 24'hABCDEF);
        single(600, 200, 0, mk(0, 0, 24'h000034), "after_reset_off");
        frame();
        single(600, 200, 0, mk(1, 0, 24'hABCDEF), "after_reset_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
